// File: rtl/bsr_pkg.sv
// Shared definitions for the BSR metadata walker and its downstream scheduler:
// walker states, default widths and the block descriptor layout.
package bsr_pkg;

    localparam int BSR_DATA_WIDTH = 32;
    localparam int BSR_ADDR_WIDTH = 32;
    localparam int BSR_ROW_WIDTH  = 16;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQ_P0  = 4'd1,
        ST_WAIT_P0 = 4'd2,
        ST_REQ_PN  = 4'd3,
        ST_WAIT_PN = 4'd4,
        ST_REQ_C   = 4'd5,
        ST_WAIT_C  = 4'd6,
        ST_EMIT    = 4'd7,
        ST_FIN     = 4'd8
    } walk_state_e;

    typedef struct packed {
        logic [BSR_ROW_WIDTH-1:0]  row;
        logic [BSR_ROW_WIDTH-1:0]  col;
        logic [BSR_DATA_WIDTH-1:0] idx;
        logic                      row_first;
        logic                      row_last;
    } blk_desc_t;

    function automatic logic is_req_state(input walk_state_e st);
        return (st == ST_REQ_P0) || (st == ST_REQ_PN) || (st == ST_REQ_C);
    endfunction

    function automatic logic is_wait_state(input walk_state_e st);
        return (st == ST_WAIT_P0) || (st == ST_WAIT_PN) || (st == ST_WAIT_C);
    endfunction

endpackage

// File: rtl/bsr_meta_walker.sv
// Walks a BSR matrix one block-row at a time, fetching row_ptr/col_idx words
// through meta_decode and emitting one descriptor per nonzero block.
module bsr_meta_walker
    import bsr_pkg::*;
#(
    parameter int DATA_WIDTH = BSR_DATA_WIDTH,
    parameter int ADDR_WIDTH = BSR_ADDR_WIDTH,
    parameter int ROW_WIDTH  = BSR_ROW_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  cfg_num_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_row_ptr_base,
    input  logic [ADDR_WIDTH-1:0] cfg_col_idx_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err_bad_ptr,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    input  logic                  meta_valid,
    input  logic [DATA_WIDTH-1:0] meta_rdata,
    output logic                  meta_ready,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [ROW_WIDTH-1:0]  blk_row,
    output logic [ROW_WIDTH-1:0]  blk_col,
    output logic [DATA_WIDTH-1:0] blk_idx,
    output logic                  blk_row_first,
    output logic                  blk_row_last,
    output logic [31:0]           stat_blocks
);

    walk_state_e           state_q, state_d;
    logic [ROW_WIDTH-1:0]  num_rows_q, num_rows_d;
    logic [ADDR_WIDTH-1:0] rp_base_q, rp_base_d;
    logic [ADDR_WIDTH-1:0] ci_base_q, ci_base_d;
    logic [DATA_WIDTH-1:0] ptr_cur_q, ptr_cur_d;
    logic [DATA_WIDTH-1:0] ptr_next_q, ptr_next_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic [ROW_WIDTH-1:0]  r_q, r_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  meta_ready_q, meta_ready_d;
    logic                  blk_valid_q, blk_valid_d;
    blk_desc_t             desc_q, desc_d;
    logic [31:0]           stat_q, stat_d;

    logic                  row_adv;
    logic [DATA_WIDTH-1:0] k_inc;

    assign k_inc = k_q + DATA_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        rp_base_d   = rp_base_q;
        ci_base_d   = ci_base_q;
        ptr_cur_d   = ptr_cur_q;
        ptr_next_d  = ptr_next_q;
        k_d         = k_q;
        r_d         = r_q;
        err_d       = err_q;
        blk_valid_d = blk_valid_q;
        desc_d      = desc_q;
        stat_d      = stat_q;
        done_d      = 1'b0;
        row_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_rows_d = cfg_num_rows;
                    rp_base_d  = cfg_row_ptr_base;
                    ci_base_d  = cfg_col_idx_base;
                    ptr_cur_d  = '0;
                    ptr_next_d = '0;
                    k_d        = '0;
                    r_d        = '0;
                    err_d      = 1'b0;
                    stat_d     = '0;
                    if (cfg_num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ_P0;
                    end
                end
            end
            ST_REQ_P0: if (req_ready) state_d = ST_WAIT_P0;
            ST_WAIT_P0: begin
                if (meta_valid) begin
                    ptr_cur_d = meta_rdata;
                    r_d       = '0;
                    state_d   = ST_REQ_PN;
                end
            end
            ST_REQ_PN: if (req_ready) state_d = ST_WAIT_PN;
            ST_WAIT_PN: begin
                if (meta_valid) begin
                    ptr_next_d = meta_rdata;
                    if (meta_rdata < ptr_cur_q) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (meta_rdata == ptr_cur_q) begin
                        row_adv = 1'b1;
                    end else begin
                        k_d     = ptr_cur_q;
                        state_d = ST_REQ_C;
                    end
                end
            end
            ST_REQ_C: if (req_ready) state_d = ST_WAIT_C;
            ST_WAIT_C: begin
                if (meta_valid) begin
                    desc_d.row       = BSR_ROW_WIDTH'(r_q);
                    desc_d.col       = BSR_ROW_WIDTH'(meta_rdata[ROW_WIDTH-1:0]);
                    desc_d.idx       = BSR_DATA_WIDTH'(k_q);
                    desc_d.row_first = (k_q == ptr_cur_q);
                    desc_d.row_last  = (k_inc == ptr_next_q);
                    blk_valid_d      = 1'b1;
                    state_d          = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (blk_ready) begin
                    blk_valid_d = 1'b0;
                    stat_d      = stat_q + 32'd1;
                    k_d         = k_inc;
                    if (k_inc == ptr_next_q) begin
                        row_adv = 1'b1;
                    end else begin
                        state_d = ST_REQ_C;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Row advance compares the pre-increment row against the last row index.
        if (row_adv) begin
            ptr_cur_d = ptr_next_d;
            r_d       = r_q + ROW_WIDTH'(1);
            state_d   = (r_q == num_rows_q - ROW_WIDTH'(1)) ? ST_FIN : ST_REQ_PN;
        end

        // Handshake outputs are registered from the next state so they line up with it.
        req_valid_d  = is_req_state(state_d);
        meta_ready_d = (state_d == ST_IDLE) || is_wait_state(state_d);
        busy_d       = (state_d != ST_IDLE);
        if (state_d == ST_FIN) done_d = 1'b1;

        case (state_d)
            ST_REQ_P0: req_addr_d = rp_base_d;
            ST_REQ_PN: req_addr_d = rp_base_d + ADDR_WIDTH'(r_d) + ADDR_WIDTH'(1);
            ST_REQ_C:  req_addr_d = ci_base_d + ADDR_WIDTH'(k_d);
            default:   req_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            num_rows_q   <= '0;
            rp_base_q    <= '0;
            ci_base_q    <= '0;
            ptr_cur_q    <= '0;
            ptr_next_q   <= '0;
            k_q          <= '0;
            r_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            meta_ready_q <= 1'b1;
            blk_valid_q  <= 1'b0;
            desc_q       <= '0;
            stat_q       <= '0;
        end else begin
            state_q      <= state_d;
            num_rows_q   <= num_rows_d;
            rp_base_q    <= rp_base_d;
            ci_base_q    <= ci_base_d;
            ptr_cur_q    <= ptr_cur_d;
            ptr_next_q   <= ptr_next_d;
            k_q          <= k_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            meta_ready_q <= meta_ready_d;
            blk_valid_q  <= blk_valid_d;
            desc_q       <= desc_d;
            stat_q       <= stat_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_bad_ptr   = err_q;
    assign req_valid     = req_valid_q;
    assign req_addr      = req_addr_q;
    assign meta_ready    = meta_ready_q;
    assign blk_valid     = blk_valid_q;
    assign blk_row       = ROW_WIDTH'(desc_q.row);
    assign blk_col       = ROW_WIDTH'(desc_q.col);
    assign blk_idx       = DATA_WIDTH'(desc_q.idx);
    assign blk_row_first = desc_q.row_first;
    assign blk_row_last  = desc_q.row_last;
    assign stat_blocks   = stat_q;

endmodule

// File: tb/tb_bsr_meta_walker.sv
// Randomized bench for bsr_meta_walker: a memory-backed meta_decode responder,
// a row-by-row reference walk of the BSR arrays, and live descriptor checking.
module tb_bsr_meta_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_num_rows = '0;
    logic [31:0] cfg_row_ptr_base = '0;
    logic [31:0] cfg_col_idx_base = '0;
    logic        busy, done, err_bad_ptr, req_valid, meta_ready, blk_valid;
    logic [31:0] req_addr, blk_idx, stat_blocks;
    logic        req_ready = 1'b0;
    logic        meta_valid = 1'b0;
    logic [31:0] meta_rdata = '0;
    logic        blk_ready = 1'b0;
    logic [15:0] blk_row, blk_col;
    logic        blk_row_first, blk_row_last;

    always #5 clk = ~clk;

    bsr_meta_walker dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_rows(cfg_num_rows), .cfg_row_ptr_base(cfg_row_ptr_base),
        .cfg_col_idx_base(cfg_col_idx_base),
        .busy(busy), .done(done), .err_bad_ptr(err_bad_ptr),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .meta_valid(meta_valid), .meta_rdata(meta_rdata), .meta_ready(meta_ready),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_row(blk_row),
        .blk_col(blk_col), .blk_idx(blk_idx), .blk_row_first(blk_row_first),
        .blk_row_last(blk_row_last), .stat_blocks(stat_blocks)
    );

    typedef struct {
        logic [15:0] row;
        logic [15:0] col;
        logic [31:0] idx;
        logic        first;
        logic        last;
    } desc_t;

    logic [31:0] mem [64];
    desc_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] addr_q[$];
    int          exp_err, exp_total;
    int          n_tests = 0, n_fail = 0;

    int          got_desc, done_cnt, req_mode, blk_mode, req_wait, blk_wait, junk;
    int          resp_delay;
    bit          busy_seen, req_seen, resp_pending, prev_req_stall, prev_blk_stall, prev_done;
    logic [31:0] resp_addr, prev_req_addr;
    logic [65:0] prev_blk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, exp);
        end
    endtask

    // Reference walk: straight iteration over rows and the blocks between row pointers.
    task automatic model(input int nrows, input logic [31:0] rpb, input logic [31:0] cib);
        logic [31:0] ptr, nxt, a, w;
        desc_t d;
        exp_q.delete();
        exp_addr_q.delete();
        exp_err = 0;
        if (nrows != 0) begin
            exp_addr_q.push_back(rpb);
            ptr = mem[rpb[5:0]];
            for (int r = 0; r < nrows; r++) begin
                a = rpb + 32'(r) + 32'd1;
                exp_addr_q.push_back(a);
                nxt = mem[a[5:0]];
                if (nxt < ptr) begin
                    exp_err = 1;
                    break;
                end
                for (logic [31:0] k = ptr; k < nxt; k++) begin
                    a = cib + k;
                    exp_addr_q.push_back(a);
                    w = mem[a[5:0]];
                    d.row = 16'(r);
                    d.col = w[15:0];
                    d.idx = k;
                    d.first = (k == ptr);
                    d.last = (k == nxt - 32'd1);
                    exp_q.push_back(d);
                end
                ptr = nxt;
            end
        end
        exp_total = exp_q.size();
    endtask

    // meta_decode responder, handshake drivers and descriptor monitor, all at negedge.
    initial forever begin
        desc_t d;
        @(negedge clk);
        if (rst) begin
            resp_pending = 0; meta_valid = 0; req_ready = 0; blk_ready = 0;
            prev_req_stall = 0; prev_blk_stall = 0; prev_done = 0;
            req_wait = 0; blk_wait = 0;
            continue;
        end
        meta_valid = 1'b0;
        meta_rdata = '0;
        if (junk > 0) begin
            junk--;
            meta_valid = 1'b1;
            meta_rdata = $urandom;
        end else if (resp_pending) begin
            if (resp_delay > 0) resp_delay--;
            else begin
                meta_valid = 1'b1;
                meta_rdata = mem[resp_addr[5:0]];
                if (meta_ready) resp_pending = 0;
            end
        end

        if (prev_req_stall) begin
            chk("req_hold_valid", req_valid, 1);
            chk("req_hold_addr", req_addr, prev_req_addr);
        end
        case (req_mode)
            0: req_ready = 1'b1;
            1: req_ready = req_valid && (req_wait >= 4);
            default: req_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (req_valid && !req_ready) req_wait++;
        if (req_valid && req_ready) begin
            req_wait = 0;
            req_seen = 1;
            chk("single_outstanding", resp_pending, 0);
            addr_q.push_back(req_addr);
            resp_pending = 1;
            resp_addr = req_addr;
            resp_delay = (req_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        end
        prev_req_stall = req_valid && !req_ready;
        prev_req_addr = req_addr;

        if (blk_valid) chk("no_req_during_emit", req_valid, 0);
        if (prev_blk_stall) begin
            chk("blk_hold_valid", blk_valid, 1);
            chk("blk_hold_payload", {blk_row, blk_col, blk_idx, blk_row_first, blk_row_last}, prev_blk);
        end
        case (blk_mode)
            0: blk_ready = 1'b1;
            1: blk_ready = blk_valid && (blk_wait >= 5);
            4: blk_ready = (got_desc == 0);
            default: blk_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (blk_valid && !blk_ready) blk_wait++;
        if (blk_valid && blk_ready) begin
            blk_wait = 0;
            got_desc++;
            if (exp_q.size() == 0) chk("extra_desc", 1, 0);
            else begin
                d = exp_q.pop_front();
                chk("desc_row", blk_row, d.row);
                chk("desc_col", blk_col, d.col);
                chk("desc_idx", blk_idx, d.idx);
                chk("desc_first_last", {blk_row_first, blk_row_last}, {d.first, d.last});
            end
        end
        prev_blk_stall = blk_valid && !blk_ready;
        prev_blk = {blk_row, blk_col, blk_idx, blk_row_first, blk_row_last};

        if (done) begin
            done_cnt++;
            chk("done_one_cycle", prev_done, 0);
        end
        prev_done = done;
        if (busy) busy_seen = 1;
    end

    task automatic run(input int nrows, input logic [31:0] rpb, input logic [31:0] cib,
                       input int rmode, input int bmode, input bit disturb);
        int c;
        model(nrows, rpb, cib);
        addr_q.delete();
        got_desc = 0; done_cnt = 0; busy_seen = 0; req_seen = 0;
        req_mode = rmode; blk_mode = bmode;
        junk = 2;
        repeat (3) @(negedge clk);
        cfg_num_rows = 16'(nrows);
        cfg_row_ptr_base = rpb;
        cfg_col_idx_base = cib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_num_rows = 16'($urandom);
        cfg_row_ptr_base = $urandom;
        cfg_col_idx_base = $urandom;
        chk("err_cleared", err_bad_ptr, 0);
        if (nrows == 0) chk("zero_done_latency", done, 1);
        if (disturb) begin
            repeat (2) @(negedge clk);
            if (busy) begin
                cfg_num_rows = '0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        c = 0;
        while (done_cnt == 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("walk_timeout", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("desc_count", got_desc, exp_total);
        chk("addr_count", addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < addr_q.size() && i < exp_addr_q.size(); i++)
            chk("addr_seq", addr_q[i], exp_addr_q[i]);
        chk("err_bad_ptr", err_bad_ptr, exp_err);
        chk("stat_blocks", stat_blocks, exp_total);
        chk("busy_after", busy, 0);
        chk("busy_seen", busy_seen, nrows != 0);
        chk("req_seen", req_seen, nrows != 0);
        if (done_cnt == 0) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic load_case1();
        mem[0] = 0; mem[1] = 2; mem[2] = 2; mem[3] = 3;
        mem[16] = 5; mem[17] = 1; mem[18] = 7;
    endtask

    task automatic rand_run();
        int n, rpb, p, bad;
        n = $urandom_range(1, 6);
        rpb = $urandom_range(0, 15);
        p = $urandom_range(0, 3);
        bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
        mem[rpb] = 32'(p);
        for (int i = 1; i <= n; i++) begin
            if (i == bad && p > 0) p = p - int'($urandom_range(1, p));
            else p = p + int'($urandom_range(0, 3));
            mem[rpb + i] = 32'(p);
        end
        for (int i = 32; i < 64; i++) mem[i] = $urandom;
        run(n, 32'(rpb), 32'd32, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    endtask

    initial begin
        int c;
        junk = 0; req_mode = 0; blk_mode = 0;
        foreach (mem[i]) mem[i] = 32'hA5A5_0000 | 32'(i);
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_bad_ptr, 0);
        chk("rst_req", {req_valid, req_addr}, 0);
        chk("rst_meta_ready", meta_ready, 1);
        chk("rst_blk", {blk_valid, blk_row, blk_col, blk_idx, blk_row_first, blk_row_last}, 0);
        chk("rst_stat", stat_blocks, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load_case1();
        run(3, 32'd0, 32'd16, 0, 0, 0);
        run(0, 32'd0, 32'd16, 0, 0, 0);
        mem[0] = 0; mem[1] = 3; mem[2] = 1;
        run(2, 32'd0, 32'd16, 0, 0, 0);
        load_case1();
        run(3, 32'd0, 32'd16, 0, 1, 0);
        run(3, 32'd0, 32'd16, 1, 0, 0);
        // row_ptr base at the top of the address space wraps to 0
        mem[63] = 0; mem[0] = 1; mem[1] = 2; mem[16] = 32'h1234_ABCD; mem[17] = 32'hFFFF_0042;
        run(2, 32'hFFFF_FFFF, 32'd16, 2, 2, 0);

        // reset while the second descriptor is being offered
        load_case1();
        model(3, 32'd0, 32'd16);
        addr_q.delete();
        got_desc = 0; done_cnt = 0; req_mode = 0; blk_mode = 4;
        cfg_num_rows = 16'd3; cfg_row_ptr_base = 0; cfg_col_idx_base = 32'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(got_desc >= 1 && blk_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_second_emit", got_desc >= 1 && blk_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_blk_valid", blk_valid, 0);
        chk("midrst_req", {req_valid, req_addr}, 0);
        chk("midrst_meta_ready", meta_ready, 1);
        chk("midrst_stat", stat_blocks, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        mem[0] = 0; mem[1] = 1; mem[16] = 9;
        run(1, 32'd0, 32'd16, 0, 0, 0);

        for (int t = 0; t < 40; t++) rand_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
